// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data bits,
// odd parity, stop, and device ACK check, with an inter-edge watchdog.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 3000,
    parameter int TIMEOUT_CYCLES = 600000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txData,
    input  logic       txStart,
    output logic       txBusy,
    output logic       txDone,
    output logic       txError,
    input  logic       ps2Clk,
    input  logic       ps2Data,
    output logic       ps2ClkDrive,
    output logic       ps2DataDrive
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_START = IW'(INHIBIT_CYCLES - 2);
    localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQUEST,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t        r_state, w_state;
    logic [8:0]    r_frame, w_frame;
    logic [3:0]    r_bitCnt, w_bitCnt;
    logic [IW-1:0] r_inhCnt, w_inhCnt;
    logic [TW-1:0] r_toCnt, w_toCnt;
    logic          r_clkPrev;
    logic          r_clkDrive, w_clkDrive;
    logic          r_dataDrive, w_dataDrive;
    logic          r_busy, w_busy;
    logic          r_done, w_done;
    logic          r_err, w_err;
    logic          w_fall;
    logic          w_active;

    assign w_fall   = r_clkPrev & ~ps2Clk;
    assign w_active = (r_state == S_REQUEST) || (r_state == S_SHIFT) ||
                      (r_state == S_ACK) || (r_state == S_WAIT_IDLE);

    // State register plus registered copies of every output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_bitCnt    <= '0;
            r_inhCnt    <= '0;
            r_toCnt     <= '0;
            r_clkPrev   <= 1'b1;
            r_clkDrive  <= 1'b0;
            r_dataDrive <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_frame     <= w_frame;
            r_bitCnt    <= w_bitCnt;
            r_inhCnt    <= w_inhCnt;
            r_toCnt     <= w_toCnt;
            r_clkPrev   <= ps2Clk;
            r_clkDrive  <= w_clkDrive;
            r_dataDrive <= w_dataDrive;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_err       <= w_err;
        end
    end

    // Next-state and next-output logic; the watchdog overrides the protocol
    always_comb begin
        w_state     = r_state;
        w_frame     = r_frame;
        w_bitCnt    = r_bitCnt;
        w_inhCnt    = r_inhCnt;
        w_toCnt     = r_toCnt;
        w_clkDrive  = r_clkDrive;
        w_dataDrive = r_dataDrive;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_err       = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_clkDrive  = 1'b0;
                w_dataDrive = 1'b0;
                if (txStart) begin
                    w_frame    = {~^txData, txData};
                    w_bitCnt   = '0;
                    w_inhCnt   = '0;
                    w_toCnt    = '0;
                    w_clkDrive = 1'b1;
                    w_busy     = 1'b1;
                    w_state    = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                w_inhCnt = r_inhCnt + 1'b1;
                // Start bit goes low in the final inhibit cycle
                if (r_inhCnt == INH_START) begin
                    w_dataDrive = 1'b1;
                end
                if (r_inhCnt == INH_LAST) begin
                    w_clkDrive = 1'b0;
                    w_toCnt    = '0;
                    w_state    = S_REQUEST;
                end
            end
            S_REQUEST: begin
                if (w_fall) begin
                    w_dataDrive = ~r_frame[0];
                    w_frame     = r_frame >> 1;
                    w_bitCnt    = 4'd1;
                    w_state     = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_fall) begin
                    if (r_bitCnt == 4'd9) begin
                        w_dataDrive = 1'b0;
                        w_state     = S_ACK;
                    end else begin
                        w_dataDrive = ~r_frame[0];
                        w_frame     = r_frame >> 1;
                        w_bitCnt    = r_bitCnt + 1'b1;
                    end
                end
            end
            S_ACK: begin
                if (w_fall) begin
                    if (!ps2Data) begin
                        w_state = S_WAIT_IDLE;
                    end else begin
                        w_err   = 1'b1;
                        w_busy  = 1'b0;
                        w_state = S_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (ps2Clk && ps2Data) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_active) begin
            if (w_fall) begin
                w_toCnt = '0;
            end else if (r_toCnt == TO_LAST) begin
                w_clkDrive  = 1'b0;
                w_dataDrive = 1'b0;
                w_busy      = 1'b0;
                w_done      = 1'b0;
                w_err       = 1'b1;
                w_state     = S_IDLE;
            end else begin
                w_toCnt = r_toCnt + 1'b1;
            end
        end
    end

    assign txBusy       = r_busy;
    assign txDone       = r_done;
    assign txError      = r_err;
    assign ps2ClkDrive  = r_clkDrive;
    assign ps2DataDrive = r_dataDrive;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] txData;
    logic       txStart;
    logic       txBusy, txDone, txError;
    logic       ps2Clk, ps2Data;
    logic       ps2ClkDrive, ps2DataDrive;
    logic       devClk, devData;

    int checks = 0;
    int errors = 0;
    int cnt_done, cnt_err, cnt_bad;

    always #5 clk = ~clk;

    assign ps2Clk  = devClk & ~ps2ClkDrive;
    assign ps2Data = devData & ~ps2DataDrive;

    ps2_host_tx #(.INHIBIT_CYCLES(16), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .reset(reset), .txData(txData), .txStart(txStart),
        .txBusy(txBusy), .txDone(txDone), .txError(txError),
        .ps2Clk(ps2Clk), .ps2Data(ps2Data),
        .ps2ClkDrive(ps2ClkDrive), .ps2DataDrive(ps2DataDrive)
    );

    // Pulse monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (txDone === 1'b1) cnt_done++;
        if (txError === 1'b1) cnt_err++;
        if ((txDone === 1'b1 || txError === 1'b1) &&
            ((txDone & txError) === 1'b1 || txBusy !== 1'b0)) cnt_bad++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, limit 2000000");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cnt_done = 0;
        cnt_err  = 0;
        cnt_bad  = 0;
    endtask

    // Drives one transfer; device clocks at 40-cycle half period and samples
    // the data line just before each falling edge.
    task automatic run_xfer(input logic [7:0] d, input bit ack,
                            input int inj_i, input int stop_i,
                            output int inh, output bit start_ok,
                            output logic [10:0] s, output bit tmo);
        bit prev_dd, last_dd;
        tmo = 0; s = '1; start_ok = 0; inh = 0;
        prev_dd = 0; last_dd = 0;
        txData = d; txStart = 1'b1; tick(); txStart = 1'b0;
        while (ps2ClkDrive === 1'b1 && inh < 100) begin
            prev_dd = last_dd;
            last_dd = ps2DataDrive;
            inh++;
            tick();
        end
        start_ok = last_dd && !prev_dd;
        if (inh >= 100) begin
            tmo = 1;
            return;
        end
        for (int i = 0; i < 11; i++) begin
            repeat (40) tick();
            if (i == stop_i) return;
            s[i] = ps2Data;
            if (i == 10 && ack) devData = 1'b0;
            devClk = 1'b0;
            if (i == inj_i) begin
                txData = 8'h55; txStart = 1'b1; tick(); txStart = 1'b0;
                repeat (39) tick();
            end else begin
                repeat (40) tick();
            end
            devClk = 1'b1;
            if (i == 10) devData = 1'b1;
        end
        for (int k = 0; k < 200 && txBusy; k++) tick();
        if (txBusy) tmo = 1;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; txStart = 1'b0; txData = 8'h00;
        devClk = 1'b1; devData = 1'b1;
        repeat (3) tick();
        checks++; if (ps2ClkDrive !== 1'b0) begin errors++; $display("FAIL rst_clkdrv: got %b want 0", ps2ClkDrive); end
        checks++; if (ps2DataDrive !== 1'b0) begin errors++; $display("FAIL rst_datadrv: got %b want 0", ps2DataDrive); end
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", txBusy); end
        checks++; if (txDone !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", txDone); end
        checks++; if (txError !== 1'b0) begin errors++; $display("FAIL rst_err: got %b want 0", txError); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_send_ed();
        int inh; bit st; logic [10:0] s; bit tmo;
        clear_mon();
        run_xfer(8'hED, 1'b1, -1, -1, inh, st, s, tmo);
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL ed_tmo: got %b want 0", tmo); end
        checks++; if (inh !== 16) begin errors++; $display("FAIL ed_inhibit: got %0d want 16", inh); end
        checks++; if (st !== 1'b1) begin errors++; $display("FAIL ed_startdrv: got %b want 1", st); end
        checks++; if (s[0] !== 1'b0) begin errors++; $display("FAIL ed_start: got %b want 0", s[0]); end
        checks++; if (s[8:1] !== 8'hED) begin errors++; $display("FAIL ed_data: got %h want ed", s[8:1]); end
        checks++; if (s[9] !== 1'b1) begin errors++; $display("FAIL ed_parity: got %b want 1", s[9]); end
        checks++; if (s[10] !== 1'b1) begin errors++; $display("FAIL ed_stop: got %b want 1", s[10]); end
        checks++; if (cnt_done !== 1) begin errors++; $display("FAIL ed_done: got %0d want 1", cnt_done); end
        checks++; if (cnt_err !== 0) begin errors++; $display("FAIL ed_err: got %0d want 0", cnt_err); end
        checks++; if (cnt_bad !== 0) begin errors++; $display("FAIL ed_pulse_rules: got %0d want 0", cnt_bad); end
        checks++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin errors++; $display("FAIL ed_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
    endtask

    task automatic test_parity();
        int inh; bit st; logic [10:0] s; bit tmo;
        clear_mon();
        run_xfer(8'h01, 1'b1, -1, -1, inh, st, s, tmo);
        checks++; if (s[8:1] !== 8'h01) begin errors++; $display("FAIL p01_data: got %h want 01", s[8:1]); end
        checks++; if (s[9] !== 1'b0) begin errors++; $display("FAIL p01_parity: got %b want 0", s[9]); end
        checks++; if (cnt_done !== 1) begin errors++; $display("FAIL p01_done: got %0d want 1", cnt_done); end
        clear_mon();
        run_xfer(8'hFF, 1'b1, -1, -1, inh, st, s, tmo);
        checks++; if (s[8:1] !== 8'hFF) begin errors++; $display("FAIL pff_data: got %h want ff", s[8:1]); end
        checks++; if (s[9] !== 1'b1) begin errors++; $display("FAIL pff_parity: got %b want 1", s[9]); end
        checks++; if (cnt_done !== 1) begin errors++; $display("FAIL pff_done: got %0d want 1", cnt_done); end
    endtask

    task automatic test_nack();
        int inh; bit st; logic [10:0] s; bit tmo;
        clear_mon();
        run_xfer(8'hA5, 1'b0, -1, -1, inh, st, s, tmo);
        checks++; if (cnt_err !== 1) begin errors++; $display("FAIL nack_err: got %0d want 1", cnt_err); end
        checks++; if (cnt_done !== 0) begin errors++; $display("FAIL nack_done: got %0d want 0", cnt_done); end
        checks++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin errors++; $display("FAIL nack_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL nack_busy: got %b want 0", tmo); end
    endtask

    task automatic test_timeout();
        int n;
        clear_mon();
        txData = 8'hA5; txStart = 1'b1; tick(); txStart = 1'b0;
        n = 0;
        while (ps2ClkDrive === 1'b1 && n < 100) begin tick(); n++; end
        n = 0;
        while (txError !== 1'b1 && n < 2000) begin tick(); n++; end
        checks++; if (n !== 1000) begin errors++; $display("FAIL to_latency: got %0d want 1000", n); end
        checks++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin errors++; $display("FAIL to_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
        repeat (5) tick();
        checks++; if (cnt_err !== 1 || cnt_done !== 0) begin errors++; $display("FAIL to_pulses: got err=%0d done=%0d want 1/0", cnt_err, cnt_done); end
    endtask

    task automatic test_back_to_back();
        int inh; bit st; logic [10:0] s; bit tmo;
        clear_mon();
        run_xfer(8'h3C, 1'b1, 3, -1, inh, st, s, tmo);
        checks++; if (s[8:1] !== 8'h3C) begin errors++; $display("FAIL ign_data: got %h want 3c", s[8:1]); end
        checks++; if (s[9] !== 1'b1) begin errors++; $display("FAIL ign_parity: got %b want 1", s[9]); end
        checks++; if (cnt_done !== 1 || cnt_err !== 0) begin errors++; $display("FAIL ign_pulses: got done=%0d err=%0d want 1/0", cnt_done, cnt_err); end
        repeat (20) tick();
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL ign_restart: got busy=%b want 0", txBusy); end
    endtask

    task automatic test_reset_mid();
        int inh; bit st; logic [10:0] s; bit tmo;
        clear_mon();
        run_xfer(8'hED, 1'b1, -1, 5, inh, st, s, tmo);
        checks++; if (ps2DataDrive !== 1'b1) begin errors++; $display("FAIL rm_bit4: got %b want 1", ps2DataDrive); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({ps2ClkDrive, ps2DataDrive} !== 2'b00) begin errors++; $display("FAIL rm_release: got %b want 00", {ps2ClkDrive, ps2DataDrive}); end
        checks++; if (txBusy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", txBusy); end
        repeat (50) tick();
        checks++; if (cnt_done !== 0 || cnt_err !== 0) begin errors++; $display("FAIL rm_pulses: got done=%0d err=%0d want 0/0", cnt_done, cnt_err); end
        clear_mon();
        run_xfer(8'hF4, 1'b1, -1, -1, inh, st, s, tmo);
        checks++; if (inh !== 16) begin errors++; $display("FAIL f4_inhibit: got %0d want 16", inh); end
        checks++; if (s[8:1] !== 8'hF4) begin errors++; $display("FAIL f4_data: got %h want f4", s[8:1]); end
        checks++; if (s[9] !== 1'b0) begin errors++; $display("FAIL f4_parity: got %b want 0", s[9]); end
        checks++; if (cnt_done !== 1 || cnt_err !== 0) begin errors++; $display("FAIL f4_pulses: got done=%0d err=%0d want 1/0", cnt_done, cnt_err); end
    endtask

    initial begin
        reset = 1'b1; txStart = 1'b0; txData = 8'h00;
        devClk = 1'b1; devData = 1'b1;
        test_reset();
        test_send_ed();
        test_parity();
        test_nack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
